fft_stage_ctrl: RTL and testbench

Sequencer for an in-place radix-2 DIT FFT over a single dual-port sample memory and a fixed-latency butterfly unit. On a start request it walks all log2(N) stages. In each stage it issues one butterfly per cycle, giving read address pair, twiddle index and stage number. It also emits delayed write-back addresses and enables matching the butterfly latency. It sits between the top-level frame handshake and the memory/butterfly datapath, and its butterfly index comes from the team's 12-bit counter.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_stage_ctrl_cnt.sv | 31 +++
 rtl/fft_stage_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT stage sequencer.
package fft_pkg;

  // Largest supported transform order; addresses are this many bits wide.
  localparam int LOG2_MAX = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_t;

  typedef logic [LOG2_MAX-1:0] addr_t;

endpackage

// File: rtl/fft_stage_ctrl_cnt.sv
// Wrapping up-counter: counts 0..max_val while ce is high, flags the
// terminal count on over and returns to 0 on the following edge.
module fft_stage_ctrl_cnt #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             ce,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt,
  output logic             over
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg;

  assign cnt  = cnt_reg;
  assign over = ce && (cnt_reg == max_val);

  // Count register: cleared by reset or clr, wraps after max_val.
  always_ff @(posedge clk) begin
    if (!nrst || clr) begin
      cnt_reg <= '0;
    end else if (ce) begin
      cnt_reg <= over ? '0 : cnt_reg + ONE;
    end
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks all stages, issues one
// butterfly per cycle and delays the addresses to the write-back port.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2_MAX = fft_pkg::LOG2_MAX,
  parameter int BF_LAT   = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [3:0]          n_log2,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                rd_en,
  output logic [LOG2_MAX-1:0] addr_a,
  output logic [LOG2_MAX-1:0] addr_b,
  output logic [LOG2_MAX-2:0] tw_idx,
  output logic [3:0]          stage,
  output logic                wr_en,
  output logic [LOG2_MAX-1:0] wr_addr_a,
  output logic [LOG2_MAX-1:0] wr_addr_b
);

  localparam int AW = LOG2_MAX;
  localparam int TW = LOG2_MAX - 1;
  localparam logic [3:0]    L_MAX      = 4'(LOG2_MAX);
  localparam logic [3:0]    DRAIN_LAST = 4'(BF_LAT - 1);
  localparam logic [AW-1:0] ONE        = AW'(1);

  ctrl_state_t state_reg, state_next;
  logic [3:0]  l_reg, l_next;
  logic [3:0]  s_reg, s_next;
  logic [3:0]  drain_reg, drain_next;

  logic [AW-1:0] b_cnt, max_val;
  logic          over, issue, accept, bad_start;
  logic [AW-1:0] half, pos, grp, addr_a_c, addr_b_c;
  logic [TW-1:0] tw_c;

  // A start is only considered in IDLE and never in the cycle that still
  // shows busy (the done cycle), so start and done cannot coincide.
  assign accept    = start && (state_reg == IDLE) && !busy &&
                     (n_log2 != 4'd0) && (n_log2 <= L_MAX);
  assign bad_start = start && (state_reg == IDLE) && !busy &&
                     ((n_log2 == 4'd0) || (n_log2 > L_MAX));
  assign issue     = (state_reg == RUN) && !hold;
  assign max_val   = (ONE << (l_reg - 4'd1)) - ONE;

  fft_stage_ctrl_cnt #(
    .WIDTH (AW)
  ) u_bf_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (accept),
    .ce      (issue),
    .max_val (max_val),
    .cnt     (b_cnt),
    .over    (over)
  );

  // Butterfly address and twiddle arithmetic for the current (s, b).
  always_comb begin
    half     = ONE << s_reg;
    pos      = b_cnt & (half - ONE);
    grp      = b_cnt >> s_reg;
    addr_a_c = (grp << (s_reg + 4'd1)) | pos;
    addr_b_c = addr_a_c + half;
    tw_c     = pos[TW-1:0] << (l_reg - 4'd1 - s_reg);
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg <= IDLE;
      l_reg     <= '0;
      s_reg     <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      l_reg     <= l_next;
      s_reg     <= s_next;
      drain_reg <= drain_next;
    end
  end

  // Next-state logic: RUN until the stage's last butterfly issues, then
  // DRAIN for BF_LAT cycles so writes land before the next stage reads.
  always_comb begin
    state_next = state_reg;
    l_next     = l_reg;
    s_next     = s_reg;
    drain_next = drain_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          l_next     = n_log2;
          s_next     = '0;
        end
      end
      RUN: begin
        if (over) begin
          state_next = DRAIN;
          drain_next = '0;
        end
      end
      DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          if (s_reg == l_reg - 4'd1) begin
            state_next = DONE;
          end else begin
            s_next     = s_reg + 4'd1;
            state_next = RUN;
          end
        end else begin
          drain_next = drain_reg + 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered issue port and status flags.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_en  <= 1'b0;
      addr_a <= '0;
      addr_b <= '0;
      tw_idx <= '0;
      stage  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      rd_en <= issue;
      if (issue) begin
        addr_a <= addr_a_c;
        addr_b <= addr_b_c;
        tw_idx <= tw_c;
        stage  <= s_reg;
      end
      busy <= accept || (state_reg != IDLE);
      done <= (state_reg == DONE);
      err  <= bad_start;
    end
  end

  // Write-back delay line, BF_LAT taps, shifting every cycle.
  logic          pipe_v [BF_LAT];
  logic [AW-1:0] pipe_a [BF_LAT];
  logic [AW-1:0] pipe_b [BF_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < BF_LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        // First tap captures the issue port.
        always_ff @(posedge clk) begin
          if (!nrst) begin
            pipe_v[gi] <= 1'b0;
            pipe_a[gi] <= '0;
            pipe_b[gi] <= '0;
          end else begin
            pipe_v[gi] <= rd_en;
            pipe_a[gi] <= addr_a;
            pipe_b[gi] <= addr_b;
          end
        end
      end else begin : g_tail
        // Later taps shift from the previous tap.
        always_ff @(posedge clk) begin
          if (!nrst) begin
            pipe_v[gi] <= 1'b0;
            pipe_a[gi] <= '0;
            pipe_b[gi] <= '0;
          end else begin
            pipe_v[gi] <= pipe_v[gi-1];
            pipe_a[gi] <= pipe_a[gi-1];
            pipe_b[gi] <= pipe_b[gi-1];
          end
        end
      end
    end
  endgenerate

  assign wr_en     = pipe_v[BF_LAT-1];
  assign wr_addr_a = pipe_a[BF_LAT-1];
  assign wr_addr_b = pipe_b[BF_LAT-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl with a schedule-level reference.
module tb_fft_stage_ctrl;
  import fft_pkg::*;

  localparam int BF_LAT = 4;
  localparam int MAXC   = 32768;

  logic        clk = 1'b0;
  logic        nrst, start, hold;
  logic [3:0]  n_log2;
  logic        busy, done, err, rd_en, wr_en;
  addr_t       addr_a, addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2_MAX-2:0] tw_idx;
  logic [3:0]  stage;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .n_log2    (n_log2),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_en     (rd_en),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .stage     (stage),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  // Reference schedule, indexed by cycle after the start-accepting edge.
  bit e_rd  [MAXC];
  int e_a   [MAXC];
  int e_b   [MAXC];
  int e_tw  [MAXC];
  int e_s   [MAXC];
  bit h_drv [MAXC];
  int e_done;

  function automatic logic [77:0] all_outs();
    return {busy, done, err, rd_en, wr_en, addr_a, addr_b, tw_idx, stage,
            wr_addr_a, wr_addr_b};
  endfunction

  // Build hold stimulus and the expected issue timeline from plain
  // arithmetic: each butterfly waits out hold, each stage adds BF_LAT.
  task automatic build_schedule(input int l, input int mode);
    int t, n, half, pos, grp;
    for (int k = 0; k < MAXC; k++) begin
      e_rd[k] = 1'b0; h_drv[k] = 1'b0;
      e_a[k] = 0; e_b[k] = 0; e_tw[k] = 0; e_s[k] = 0;
    end
    if (mode == 1) begin
      for (int k = 0; k < MAXC; k++) h_drv[k] = ($urandom_range(3) == 0);
    end else if (mode == 2) begin
      for (int k = 10; k <= 12; k++) h_drv[k] = 1'b1;
    end
    n = 1 << l;
    t = 0;
    for (int s = 0; s < l; s++) begin
      half = 1 << s;
      for (int bb = 0; bb < n / 2; bb++) begin
        while (h_drv[t]) t++;
        pos = bb % half;
        grp = bb / half;
        e_rd[t+1] = 1'b1;
        e_a[t+1]  = grp * 2 * half + pos;
        e_b[t+1]  = grp * 2 * half + pos + half;
        e_tw[t+1] = pos * (1 << (l - 1 - s));
        e_s[t+1]  = s;
        t++;
      end
      t += BF_LAT;
    end
    e_done = t + 1;
  endtask

  // One full transform; junk=1 also pulses start while busy and in the done cycle.
  task automatic run_transform(input int l, input int mode, input bit junk);
    int issued;
    logic [4:0]  obs_f, exp_f;
    logic [38:0] obs_rd, exp_rd;
    logic [23:0] obs_wr, exp_wr;
    bit wr_exp;
    build_schedule(l, mode);
    @(negedge clk);
    start  = 1'b1;
    n_log2 = 4'(l);
    @(posedge clk);
    #1;
    start  = 1'b0;
    issued = 0;
    for (int k = 0; k <= e_done + BF_LAT + 4; k++) begin
      @(negedge clk);
      wr_exp = (k >= BF_LAT) ? e_rd[k-BF_LAT] : 1'b0;
      obs_f  = {rd_en, wr_en, done, busy, err};
      exp_f  = {e_rd[k], wr_exp, (k == e_done), (k <= e_done), 1'b0};
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL flags L=%0d cycle=%0d {rd,wr,done,busy,err} got=%b want=%b",
                 l, k, obs_f, exp_f);
      end
      if (e_rd[k]) begin
        obs_rd = {addr_a, addr_b, tw_idx, stage};
        exp_rd = {addr_t'(e_a[k]), addr_t'(e_b[k]), 11'(e_tw[k]), 4'(e_s[k])};
        checks++;
        if (obs_rd !== exp_rd) begin
          errors++;
          $display("FAIL issue L=%0d cycle=%0d a/b/tw/s got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                   l, k, addr_a, addr_b, tw_idx, stage, e_a[k], e_b[k], e_tw[k], e_s[k]);
        end
      end
      if (wr_exp) begin
        obs_wr = {wr_addr_a, wr_addr_b};
        exp_wr = {addr_t'(e_a[k-BF_LAT]), addr_t'(e_b[k-BF_LAT])};
        checks++;
        if (obs_wr !== exp_wr) begin
          errors++;
          $display("FAIL writeback L=%0d cycle=%0d a/b got=%0d/%0d want=%0d/%0d",
                   l, k, wr_addr_a, wr_addr_b, e_a[k-BF_LAT], e_b[k-BF_LAT]);
        end
      end
      if (rd_en === 1'b1) issued++;
      hold   = h_drv[k];
      n_log2 = 4'($urandom_range(15));
      if (junk && k < e_done)       start = ($urandom_range(1) == 1);
      else if (junk && k == e_done) start = 1'b1;
      else                          start = 1'b0;
    end
    hold  = 1'b0;
    start = 1'b0;
    checks++;
    if (issued != l * ((1 << l) / 2)) begin
      errors++;
      $display("FAIL issue_count L=%0d got=%0d want=%0d", l, issued, l * ((1 << l) / 2));
    end
    $display("run L=%0d mode=%0d issues=%0d done_cycle=%0d", l, mode, issued, e_done);
  endtask

  task automatic test_reset();
    nrst = 1'b0; start = 1'b0; hold = 1'b0; n_log2 = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL idle_outputs got=%h want=0", all_outs());
    end
    $display("reset outputs=%h", all_outs());
  endtask

  task automatic test_bad_start();
    logic [3:0] vals [3];
    vals[0] = 4'd0;
    vals[1] = 4'd13;
    vals[2] = 4'($urandom_range(15, 13));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start  = 1'b1;
      n_log2 = vals[i];
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({err, busy} !== 2'b10) begin
        errors++;
        $display("FAIL bad_start_pulse n_log2=%0d {err,busy} got=%b want=10", vals[i], {err, busy});
      end
      @(negedge clk);
      checks++;
      if ({err, busy} !== 2'b00) begin
        errors++;
        $display("FAIL bad_start_after n_log2=%0d {err,busy} got=%b want=00", vals[i], {err, busy});
      end
      $display("bad start n_log2=%0d err=%b busy=%b", vals[i], err, busy);
    end
  endtask

  // Abort during stage 1 RUN; the next cycle must show the reset state.
  task automatic test_abort();
    @(negedge clk);
    start  = 1'b1;
    n_log2 = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= 10; k++) @(negedge clk);
    nrst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
        errors++;
        $display("FAIL abort_outputs step=%0d got=%h want=0", j, all_outs());
      end
      nrst = 1'b1;
    end
    $display("abort in stage 1 outputs=%h", all_outs());
    run_transform(1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_bad_start();
    run_transform(3, 0, 1'b1);
    run_transform(3, 2, 1'b0);
    for (int i = 0; i < 3; i++) run_transform($urandom_range(5, 1), 1, 1'b1);
    test_abort();
    run_transform(12, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
